// File: rtl/uart_bridge.sv
// UART command bridge: decodes read/write byte commands from the uart receive FIFO,
// runs one req/ack bus transaction, and answers through the transmit FIFO.
// Optional inter-byte timeout enabled by defining UART_BRIDGE_TIMEOUT_EN.
module uart_bridge #(
  parameter int ADDR_   = 16,
  parameter int DATA_   = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             rxavail,
  output logic             re,
  input  logic [7:0]       rxbyte,
  input  logic             txavail,
  output logic             we,
  output logic [7:0]       txbyte,
  output logic             busreq,
  output logic             buswe,
  output logic [ADDR_-1:0] busaddr,
  output logic [DATA_-1:0] buswdata,
  input  logic [DATA_-1:0] busrdata,
  input  logic             busack,
  output logic             busy,
  output logic             err
);

  localparam int NA   = ADDR_ / 8;
  localparam int ND   = DATA_ / 8;
  localparam int NMAX = (NA > ND) ? NA : ND;
  localparam int CW   = $clog2(NMAX) + 1;

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, BUS, SEND} state_t;

  state_t          state, state_n;
  logic            pend;     // re issued in ADDR/WDATA, byte arrives this cycle
  logic [CW-1:0]   cnt;
  logic [DATA_-1:0] cap;
  logic            fetch;
  logic            timeout;

  assign fetch = (state == ADDR) || (state == WDATA);

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge clk) begin
    if (!rst_ || !fetch || pend) tcnt <= '0;
    else if (!timeout)           tcnt <= tcnt + 1'b1;
  end

  assign timeout = (tcnt == TW'(TIMEOUT));
`else
  // No counter: always 0, written against TIMEOUT so the parameter stays referenced.
  assign timeout = (TIMEOUT < 0);
`endif

  always_comb begin
    state_n = state;
    re      = 1'b0;
    we      = 1'b0;
    err     = 1'b0;
    busreq  = 1'b0;
    txbyte  = '0;
    busy    = (state != IDLE);
    case (state)
      IDLE: if (rxavail) begin
        re      = 1'b1;
        state_n = CMD;
      end
      CMD: begin
        if (rxbyte == CMD_WR || rxbyte == CMD_RD) state_n = ADDR;
        else begin
          err     = 1'b1;
          state_n = SEND;
        end
      end
      ADDR, WDATA: begin
        if (pend) begin
          if (cnt == CW'(1)) state_n = (state == ADDR && buswe) ? WDATA : BUS;
        end else if (timeout) begin
          err     = 1'b1;
          state_n = IDLE;
        end else if (rxavail) begin
          re = 1'b1;
        end
      end
      BUS: begin
        busreq = 1'b1;
        if (busack) state_n = SEND;
      end
      SEND: if (txavail) begin
        we     = 1'b1;
        txbyte = cap[DATA_-1 -: 8];
        if (cnt == CW'(1)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Strobes and status are held low throughout the reset cycle itself.
    if (!rst_) begin
      re     = 1'b0;
      we     = 1'b0;
      err    = 1'b0;
      busreq = 1'b0;
      busy   = 1'b0;
      txbyte = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state    <= IDLE;
      pend     <= 1'b0;
      cnt      <= '0;
      cap      <= '0;
      buswe    <= 1'b0;
      busaddr  <= '0;
      buswdata <= '0;
    end else begin
      state <= state_n;
      pend  <= fetch && re;
      case (state)
        CMD: begin
          buswe <= (rxbyte == CMD_WR);
          if (rxbyte == CMD_WR || rxbyte == CMD_RD) cnt <= CW'(NA);
          else begin
            cap <= DATA_'(RSP_NAK) << (DATA_ - 8);
            cnt <= CW'(1);
          end
        end
        ADDR: if (pend) begin
          busaddr <= ADDR_'({busaddr, rxbyte});
          cnt     <= (cnt == CW'(1)) ? CW'(ND) : cnt - 1'b1;
        end
        WDATA: if (pend) begin
          buswdata <= DATA_'({buswdata, rxbyte});
          cnt      <= cnt - 1'b1;
        end
        BUS: if (busack) begin
          if (buswe) begin
            cap <= DATA_'(RSP_ACK) << (DATA_ - 8);
            cnt <= CW'(1);
          end else begin
            cap <= busrdata;
            cnt <= CW'(ND);
          end
        end
        SEND: if (txavail) begin
          cap <= cap << 8;
          cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_bridge.sv
// Self-checking bench for uart_bridge: table-driven commands with rx/bus/tx models
// and scoreboards, plus hand-written bad-command, backpressure, reset and late-byte cases.
module tb_uart_bridge;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          rxavail = 1'b0;
  logic          re;
  logic [7:0]    rxbyte = '0;
  logic          txavail = 1'b1;
  logic          we;
  logic [7:0]    txbyte;
  logic          busreq, buswe;
  logic [AW-1:0] busaddr;
  logic [DW-1:0] buswdata;
  logic [DW-1:0] busrdata = '0;
  logic          busack = 1'b0;
  logic          busy, err;

  always #5 clk = ~clk;

  uart_bridge #(.ADDR_(AW), .DATA_(DW), .TIMEOUT(1000)) dut (
    .clk(clk), .rst_(rst_), .rxavail(rxavail), .re(re), .rxbyte(rxbyte),
    .txavail(txavail), .we(we), .txbyte(txbyte), .busreq(busreq), .buswe(buswe),
    .busaddr(busaddr), .buswdata(buswdata), .busrdata(busrdata), .busack(busack),
    .busy(busy), .err(err)
  );

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;
    int          dly;
  } bus_t;

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [31:0] data;   // write data, or read data returned by the bus model
    int          dly;    // cycles from busreq seen to busack
    int          exp_n;  // expected number of response bytes
  } vec_t;

  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  bus_t       bus_exp[$];
  bus_t       cur;

  int pass_cnt = 0, total = 0;
  int err_cnt = 0, tx_seen = 0, tx_block = 0, ack_cnt = 0;
  bit bus_active = 0, bp_arm = 0, prev_re = 0, prev_err = 0;
  bit last_busy = 0, last_re = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    logic re_s, we_s, req_s, err_s;
    logic [8:0] e;
    @(negedge clk);
    re_s = re; we_s = we; req_s = busreq; err_s = err;
    last_busy = busy; last_re = re;
    if (re_s) begin
      chk("re_rxavail", rxavail, 1);
      chk("re_spacing", prev_re, 0);
    end
    if (we_s) begin
      chk("we_txavail", txavail, 1);
      e = (tx_exp.size() != 0) ? {1'b0, tx_exp.pop_front()} : 9'h100;
      chk("tx_byte", {1'b0, txbyte}, e);
      tx_seen++;
    end
    if (err_s) begin
      err_cnt++;
      chk("err_width", prev_err, 0);
    end
    if (req_s && !bus_active && !busack) begin
      if (bus_exp.size() == 0) chk("bus_unexpected", req_s, 0);
      else begin
        cur = bus_exp.pop_front();
        chk("buswe", buswe, cur.wr);
        chk("busaddr", busaddr, cur.addr);
        if (cur.wr) chk("buswdata", buswdata, cur.data);
        bus_active = 1;
        ack_cnt = cur.dly;
      end
    end else if (bus_active) begin
      chk("busreq_hold", req_s, 1);
    end
    @(posedge clk);
    #1;
    if (re_s) rxbyte = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
    busack = 1'b0;
    busrdata = '0;
    if (bus_active) begin
      if (ack_cnt == 0) begin
        busack = 1'b1;
        busrdata = cur.data;
        bus_active = 0;
      end else ack_cnt--;
    end
    if (bp_arm && we_s) begin
      tx_block = 100;
      bp_arm = 0;
    end
    if (tx_block > 0) begin
      tx_block--;
      txavail = 1'b0;
      if (tx_block == 50) begin   // stray ack with busreq low
        busack = 1'b1;
        busrdata = 32'hBAD0BAD0;
      end
    end else txavail = 1'b1;
    rxavail = (rx_q.size() != 0);
    prev_re = re_s;
    prev_err = err_s;
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
    rxavail = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      step();
      n++;
      done = !last_busy && !last_re && rx_q.size() == 0 && tx_exp.size() == 0 &&
             !bus_active && bus_exp.size() == 0;
    end
    chk("done_in_budget", done, 1);
  endtask

  task automatic expect_cmd(input vec_t v);
    bus_t b;
    b.wr = v.wr; b.addr = v.addr; b.data = v.data; b.dly = v.dly;
    bus_exp.push_back(b);
    if (v.wr) tx_exp.push_back(8'h06);
    else for (int i = 0; i < 4; i++) tx_exp.push_back(v.data[31-8*i -: 8]);
  endtask

  task automatic run_vec(input vec_t v);
    int start;
    start = tx_seen;
    send(v.wr ? 8'h57 : 8'h52);
    send(v.addr[15:8]);
    send(v.addr[7:0]);
    if (v.wr) for (int i = 0; i < 4; i++) send(v.data[31-8*i -: 8]);
    expect_cmd(v);
    wait_done(2000);
    chk("tx_count", tx_seen - start, v.exp_n);
  endtask

  task automatic chk_zero();
    chk("rst_re", re, 0);
    chk("rst_we", we, 0);
    chk("rst_txbyte", txbyte, 0);
    chk("rst_busreq", busreq, 0);
    chk("rst_buswe", buswe, 0);
    chk("rst_busaddr", busaddr, 0);
    chk("rst_buswdata", buswdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
  endtask

  vec_t vecs[5];
  vec_t v;
  int   e0, t0;

  initial begin
    vecs[0] = '{1, 16'h0010, 32'hDEADBEEF, 5, 1};
    vecs[1] = '{0, 16'h1234, 32'hCAFEF00D, 3, 4};
    vecs[2] = '{1, 16'hFFFF, 32'h00000001, 0, 1};
    vecs[3] = '{0, 16'h0000, 32'h12345678, 1, 4};
    vecs[4] = '{1, 16'h8001, 32'hA5A5A5A5, 2, 1};

    for (int i = 0; i < 3; i++) step();
    rst_ = 1'b1;
    chk_zero();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Bad command, then a read.
    e0 = err_cnt; t0 = tx_seen;
    send(8'h41);
    tx_exp.push_back(8'h15);
    wait_done(200);
    chk("bad_err_count", err_cnt - e0, 1);
    chk("bad_tx_count", tx_seen - t0, 1);
    v = '{0, 16'h0004, 32'h0BADF00D, 2, 4};
    run_vec(v);

    // Transmit backpressure mid-response, with a stray busack.
    bp_arm = 1;
    v = '{0, 16'h4321, 32'h01234567, 4, 4};
    run_vec(v);

    // Reset in the middle of a write command.
    send(8'h57);
    send(8'h00);
    for (int i = 0; i < 4; i++) step();
    rst_ = 1'b0;
    step();
    rst_ = 1'b1;
    chk_zero();
    v = '{1, 16'h0020, 32'h11223344, 2, 1};
    run_vec(v);

    // Stall between address bytes.
    e0 = err_cnt; t0 = tx_seen;
    send(8'h52);
    send(8'h12);
`ifdef UART_BRIDGE_TIMEOUT_EN
    for (int i = 0; i < 1100; i++) step();
    chk("to_err_count", err_cnt - e0, 1);
    chk("to_tx_count", tx_seen - t0, 0);
    chk("to_idle", last_busy, 0);
    v = '{0, 16'h0008, 32'h55AA33CC, 1, 4};
    run_vec(v);
`else
    for (int i = 0; i < 1100; i++) step();
    chk("late_busy", last_busy, 1);
    chk("late_err_count", err_cnt - e0, 0);
    send(8'h34);
    v = '{0, 16'h1234, 32'h87654321, 1, 4};
    expect_cmd(v);
    wait_done(200);
    chk("late_tx_count", tx_seen - t0, 4);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
